// File: rtl/f_ADD.sv
// N-bit ripple-carry adder used as the single arithmetic element of the ALU datapath.
module f_ADD #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic c;

    // A variable carry is used so the chain is a single combinational process.
    always_comb begin
        c   = c_in;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/shift_add_mul.sv
// Multi-cycle unsigned N x N -> 2N shift-add multiplier, one multiplier bit per clock.
// Optional macro SHIFT_ADD_MUL_ZERO_BYPASS_EN: zero operands complete in one cycle.
module shift_add_mul #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CntW = $clog2(N + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]     st_q, st_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   mq_q, mq_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;

    logic [N-1:0]   add_sum;
    logic           add_cout;
    logic [2*N-1:0] shifted;

    f_ADD #(
        .N (N)
    ) u_add (
        .a     (acc_q),
        .b     (m_q),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // Carry-out lands in acc[N-1] so no product bit is ever lost.
    assign shifted = mq_q[0] ? {add_cout, add_sum, mq_q[N-1:1]}
                             : {1'b0, acc_q, mq_q[N-1:1]};

    always_comb begin
        st_d      = st_q;
        m_d       = m_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (st_q)
            StIdle: begin
                if (start) begin
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
                    if ((a == '0) || (b == '0)) begin
                        product_d = '0;
                        st_d      = StDone;
                    end else begin
                        m_d   = a;
                        mq_d  = b;
                        acc_d = '0;
                        cnt_d = CntW'(N);
                        st_d  = StRun;
                    end
`else
                    m_d   = a;
                    mq_d  = b;
                    acc_d = '0;
                    cnt_d = CntW'(N);
                    st_d  = StRun;
`endif
                end
            end
            StRun: begin
                acc_d = shifted[2*N-1:N];
                mq_d  = shifted[N-1:0];
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    product_d = shifted;
                    st_d      = StDone;
                end
            end
            StDone: st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= StIdle;
            m_q       <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            st_q      <= st_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (st_q == StRun);
    assign done    = (st_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul (N=8): stimulus pushes expected products, monitor pops on done.
module tb_shift_add_mul;

    localparam int unsigned N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [2*N-1:0] exp_q[$];
    bit b2b_phase = 0;
    bit have_last = 0;
    int last_done_cyc = 0;

    shift_add_mul #(
        .N (N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("product", 32'(product), 32'(exp_q.pop_front()));
            end
            if (b2b_phase && have_last) check("done_spacing", 32'(cyc - last_done_cyc), N + 2);
            have_last     = 1'b1;
            last_done_cyc = cyc;
        end
    end

    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input bit expect_done);
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        if (expect_done) exp_q.push_back({{N{1'b0}}, ia} * {{N{1'b0}}, ib});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done and busy cycles seen on the way; bounded.
    task automatic wait_done(input string name, input int exp_n, input int exp_busy);
        int n = 0;
        int bc = 0;
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(n), 32'(exp_n));
        check({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'd13, 8'd11, 1);
        wait_done("mul13x11", N, N);

        issue(8'hFF, 8'hFF, 1);
        wait_done("mulFFxFF", N, N);

        // Restart attempt during RUN iteration 3 must be ignored.
        issue(8'd5, 8'd6, 1);
        @(negedge clk);
        @(negedge clk);
        a     = 8'd7;
        b     = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start", N - 3, N - 3);
        repeat (N + 3) @(negedge clk);
        check("product_hold", 32'(product), 32'h001E);

        // Async reset in RUN iteration 4 aborts without done.
        issue(8'd200, 8'd3, 0);
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);

        issue(8'd2, 8'd3, 1);
        wait_done("post_reset", N, N);

        issue(8'd0, 8'd9, 1);
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
        wait_done("zero_operand", 0, 0);
`else
        wait_done("zero_operand", N, N);
`endif

        // Back-to-back with start held high; operands refreshed each time IDLE is reached.
        @(negedge clk);
        b2b_phase = 1'b1;
        have_last = 1'b0;
        for (int op = 0; op < 1000; op++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            int guard;
            ra    = N'($urandom_range(1, 255));
            rb    = N'($urandom_range(1, 255));
            a     = ra;
            b     = rb;
            start = 1'b1;
            exp_q.push_back({{N{1'b0}}, ra} * {{N{1'b0}}, rb});
            @(negedge clk);
            guard = 0;
            while ((busy || done) && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 40) begin
                check("b2b_timeout", 32'd1, 32'd0);
                break;
            end
        end
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        b2b_phase = 1'b0;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
